// File: rtl/low_pass_cascade_pkg.sv
// Shared types and width helpers for the low-pass cascade and its stage sections.
package low_pass_cascade_pkg;

    typedef enum logic {
        MODE_LP = 1'b0,
        MODE_HP = 1'b1
    } mode_e;

    localparam int DEF_WIDTH       = 16;
    localparam int DEF_ALPHA_WIDTH = 32;
    localparam int DEF_FRAC        = 16;
    localparam int DEF_STAGES      = 4;

    function automatic int state_width(input int width, input int frac);
        return width + frac;
    endfunction

    function automatic int diff_width(input int width, input int frac);
        return width + frac + 1;
    endfunction

    // Signed difference times zero-extended unsigned alpha, full precision.
    function automatic int prod_width(input int width, input int frac, input int alpha_width);
        return diff_width(width, frac) + alpha_width + 1;
    endfunction

endpackage

// File: rtl/low_pass_cascade_stage.sv
// One first-order exponential section: y += alpha*(x - y), or a registered pass-through when disabled.
module exp_filter_stage
    import low_pass_cascade_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int ALPHA_WIDTH = DEF_ALPHA_WIDTH,
    parameter int FRAC        = DEF_FRAC
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    en_i,
    input  logic                    valid_i,
    input  logic signed [WIDTH-1:0] x_i,
    input  logic [ALPHA_WIDTH-1:0]  alpha_i,
    output logic signed [WIDTH-1:0] y_o,
    output logic                    valid_o
);

    localparam int SW = state_width(WIDTH, FRAC);
    localparam int DW = diff_width(WIDTH, FRAC);
    localparam int PW = prod_width(WIDTH, FRAC, ALPHA_WIDTH);

    logic signed [SW-1:0]    y_q, y_d;
    logic signed [WIDTH-1:0] out_q, out_d;
    logic                    valid_q, valid_d;
    logic [DW-1:0]           diff_s;
    logic signed [PW-1:0]    prod_s;
    logic signed [SW-1:0]    y_upd_s;

    // Filter arithmetic and next-state selection; the floor shift keeps y between old y and x.
    always_comb begin
        diff_s  = {x_i[WIDTH-1], x_i, {FRAC{1'b0}}} - {y_q[SW-1], y_q};
        prod_s  = $signed({{(ALPHA_WIDTH+1){diff_s[DW-1]}}, diff_s})
                * $signed({{(DW+1){1'b0}}, alpha_i});
        y_upd_s = y_q + SW'(prod_s >>> ALPHA_WIDTH);
        y_d     = y_q;
        out_d   = out_q;
        valid_d = 1'b0;
        if (clear_i) begin
            y_d     = '0;
            out_d   = '0;
            valid_d = 1'b0;
        end else if (valid_i) begin
            valid_d = 1'b1;
            if (en_i) begin
                y_d   = y_upd_s;
                out_d = y_upd_s[SW-1:FRAC];
            end else begin
                out_d = x_i;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            y_q     <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign y_o     = out_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/low_pass_cascade.sv
// Cascade of STAGES exponential sections with runtime order, high-pass mode, clear and saturation flag.
module low_pass_cascade
    import low_pass_cascade_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int alpha_WIDTH = DEF_ALPHA_WIDTH,
    parameter int FRAC        = DEF_FRAC,
    parameter int STAGES      = DEF_STAGES
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic signed [WIDTH-1:0]      data_i,
    input  logic                         valid_i,
    input  logic [alpha_WIDTH-1:0]       alpha_i,
    input  logic [$clog2(STAGES+1)-1:0]  order_i,
    input  logic                         hp_i,
    input  logic                         clear_i,
    output logic signed [WIDTH-1:0]      data_o,
    output logic                         valid_o,
    output logic                         sat_o
);

    localparam int OW = $clog2(STAGES + 1);

    logic [alpha_WIDTH-1:0]  alpha_q, alpha_d;
    logic [OW-1:0]           order_q, order_d;
    mode_e                   hp_q, hp_d;
    logic signed [WIDTH-1:0] x_dly_q [0:STAGES-1];
    logic signed [WIDTH-1:0] x_dly_d [0:STAGES-1];
    logic signed [WIDTH-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    sat_q, sat_d;
    logic [WIDTH:0]          diff_s;

    logic signed [WIDTH-1:0] chain_x_s [0:STAGES];
    logic                    chain_v_s [0:STAGES];

    assign chain_x_s[0] = data_i;
    assign chain_v_s[0] = valid_i;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        exp_filter_stage #(
            .WIDTH       (WIDTH),
            .ALPHA_WIDTH (alpha_WIDTH),
            .FRAC        (FRAC)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear_i (clear_i),
            .en_i    (order_q > OW'(k)),
            .valid_i (chain_v_s[k]),
            .x_i     (chain_x_s[k]),
            .alpha_i (alpha_q),
            .y_o     (chain_x_s[k+1]),
            .valid_o (chain_v_s[k+1])
        );
    end

    // Returns {clipped, value} for a WIDTH+1 bit difference squeezed into WIDTH bits.
    function automatic logic [WIDTH:0] sat_diff(input logic [WIDTH:0] d);
        logic [WIDTH:0] r;
        if (d[WIDTH] != d[WIDTH-1]) begin
            r = d[WIDTH] ? {1'b1, 1'b1, {(WIDTH-1){1'b0}}} : {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            r = {1'b0, d[WIDTH-1:0]};
        end
        return r;
    endfunction

    // Coefficient capture, x delay line aligned with the stages, and the LP/HP output stage.
    always_comb begin
        diff_s = {x_dly_q[STAGES-1][WIDTH-1], x_dly_q[STAGES-1]}
               - {chain_x_s[STAGES][WIDTH-1], chain_x_s[STAGES]};
        alpha_d = alpha_i;
        order_d = (order_i > OW'(STAGES)) ? OW'(STAGES) : order_i;
        hp_d    = mode_e'(hp_i);
        valid_d = chain_v_s[STAGES];
        data_d  = data_q;
        sat_d   = sat_q;
        x_dly_d[0] = valid_i ? data_i : x_dly_q[0];
        for (int i = 1; i < STAGES; i++) begin
            x_dly_d[i] = chain_v_s[i] ? x_dly_q[i-1] : x_dly_q[i];
        end
        if (clear_i) begin
            alpha_d = '0;
            order_d = '0;
            hp_d    = MODE_LP;
            valid_d = 1'b0;
            data_d  = '0;
            sat_d   = 1'b0;
            for (int i = 0; i < STAGES; i++) begin
                x_dly_d[i] = '0;
            end
        end else if (chain_v_s[STAGES]) begin
            case (hp_q)
                MODE_HP: {sat_d, data_d} = sat_diff(diff_s);
                default: begin
                    data_d = chain_x_s[STAGES];
                    sat_d  = 1'b0;
                end
            endcase
        end else begin
            data_d = data_q;
            sat_d  = sat_q;
        end
    end

    // Top-level registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alpha_q <= '0;
            order_q <= '0;
            hp_q    <= MODE_LP;
            data_q  <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            for (int i = 0; i < STAGES; i++) begin
                x_dly_q[i] <= '0;
            end
        end else begin
            alpha_q <= alpha_d;
            order_q <= order_d;
            hp_q    <= hp_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
            for (int i = 0; i < STAGES; i++) begin
                x_dly_q[i] <= x_dly_d[i];
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign sat_o   = sat_q;

endmodule
